// File: rtl/narrow_saturate_pkg.sv
// Shared widths, output range limits and shift clamping for the narrowing paths
// that sit between the MAC accumulators and result writeback.
package narrow_saturate_pkg;

  localparam int IN_WIDTH_DEF    = 37;
  localparam int OUT_WIDTH_DEF   = 32;
  localparam int SHIFT_WIDTH_DEF = 6;
  localparam int CNT_WIDTH_DEF   = 16;

  function automatic longint out_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint out_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

  function automatic int shift_clamp(input int s, input int lim);
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/narrow_saturate_if.sv
// Sample/result handshake plus saturation counter access for narrow_saturate.
interface narrow_saturate_if
  import narrow_saturate_pkg::*;
#(
  parameter int IN_WIDTH    = IN_WIDTH_DEF,
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [IN_WIDTH-1:0]  in_data;
  logic [SHIFT_WIDTH-1:0]      in_shift;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_sat;
  logic                        sat_clear;
  logic [CNT_WIDTH-1:0]        sat_count;

  modport master (
    output in_valid, in_data, in_shift, out_ready, sat_clear,
    input  in_ready, out_valid, out_data, out_sat, sat_count
  );

  modport slave (
    input  in_valid, in_data, in_shift, out_ready, sat_clear,
    output in_ready, out_valid, out_data, out_sat, sat_count
  );
endinterface

// File: rtl/narrow_saturate_sat_clamp.sv
// Combinational clamp of a rounded wide value into the signed OUT_WIDTH range.
module sat_clamp
  import narrow_saturate_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic signed [IN_WIDTH:0]    r_i,
  output logic signed [OUT_WIDTH-1:0] data_o,
  output logic                        sat_o
);
  localparam logic signed [IN_WIDTH:0] MAX_R = (IN_WIDTH+1)'(out_max(OUT_WIDTH));
  localparam logic signed [IN_WIDTH:0] MIN_R = (IN_WIDTH+1)'(out_min(OUT_WIDTH));

  always_comb begin
    data_o = r_i[OUT_WIDTH-1:0];
    sat_o  = 1'b0;
    if (r_i > MAX_R) begin
      data_o = MAX_R[OUT_WIDTH-1:0];
      sat_o  = 1'b1;
    end else if (r_i < MIN_R) begin
      data_o = MIN_R[OUT_WIDTH-1:0];
      sat_o  = 1'b1;
    end
  end
endmodule

// File: rtl/narrow_saturate.sv
// Two-stage narrowing pipeline: rounding right-shift, then saturation, with full
// valid/ready backpressure and a sticky count of delivered clamped results.
module narrow_saturate
  import narrow_saturate_pkg::*;
#(
  parameter int IN_WIDTH    = IN_WIDTH_DEF,
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input logic              Clock,
  input logic              Resetn,
  narrow_saturate_if.slave bus
);
  logic                        started_q;
  logic                        vld_p1_q, vld_p2_q;
  logic signed [IN_WIDTH:0]    r_p0, r_p1_q;
  logic signed [OUT_WIDTH-1:0] data_p2_d, data_p2_q;
  logic                        sat_p2_d, sat_p2_q;
  logic [CNT_WIDTH-1:0]        cnt_d, cnt_q;
  logic                        s1_adv, s2_adv, in_fire, out_fire;

  // One guard bit keeps the rounding add exact for any clamped shift.
  function automatic logic signed [IN_WIDTH:0] round_shift(
    input logic signed [IN_WIDTH-1:0] d,
    input int                         sh
  );
    logic signed [IN_WIDTH:0] t;
    logic signed [IN_WIDTH:0] rnd;
    rnd = '0;
    if (sh != 0) rnd = (IN_WIDTH+1)'(1) << (sh - 1);
    t = {d[IN_WIDTH-1], d} + rnd;
    return t >>> sh;
  endfunction

  assign s2_adv       = !vld_p2_q || bus.out_ready;
  assign s1_adv       = !vld_p1_q || s2_adv;
  assign bus.in_ready = started_q && s1_adv;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = vld_p2_q && bus.out_ready;

  // Stage 0 -> 1: round and shift
  assign r_p0 = round_shift(bus.in_data, shift_clamp(int'(bus.in_shift), IN_WIDTH));

  always_ff @(posedge Clock) begin
    if (in_fire) r_p1_q <= r_p0;
  end

  // Stage 1 -> 2: saturate
  sat_clamp #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_sat_clamp (
    .r_i    (r_p1_q),
    .data_o (data_p2_d),
    .sat_o  (sat_p2_d)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (bus.sat_clear)                         cnt_d = '0;
    else if (out_fire && sat_p2_q && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      started_q <= 1'b0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      sat_p2_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      started_q <= 1'b1;
      if (s1_adv) vld_p1_q <= in_fire;
      if (s2_adv) begin
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) begin
          data_p2_q <= data_p2_d;
          sat_p2_q  <= sat_p2_d;
        end
      end
      cnt_q <= cnt_d;
    end
  end

  assign bus.out_valid = vld_p2_q;
  assign bus.out_data  = data_p2_q;
  assign bus.out_sat   = sat_p2_q;
  assign bus.sat_count = cnt_q;
endmodule
